// File: rtl/modexp_ctrl.sv
// ---------------------------------------------------------------------------
// modexp_ctrl
//   Left-to-right binary modular exponentiation sequencer:
//   result = msg^exp mod mod. It has no arithmetic of its own. Each square or
//   multiply is handed to an external modular multiplier through a
//   mul_start / mul_done handshake.
//
// Ports
//   clk, rst            clock and asynchronous active-high reset
//   start, ready        request handshake; start is accepted only while ready=1
//   msg, exp, mod       operands; sampled on an accepted start
//   result, done, err   result (held until the next start), one-cycle done
//                       pulse, and an illegal-operand flag
//   mul_start           one-cycle launch pulse to the multiplier
//   mul_a, mul_b, mul_n multiplier operands; stable until mul_done
//   mul_done, mul_r     multiplier completion pulse and product
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start, ready=1
// SQ_REQ   | mul_start pulse for acc*acc
// SQ_WAIT  | waiting for the square product
// MUL_REQ  | mul_start pulse for acc*msg
// MUL_WAIT | waiting for the multiply product
// NEXT     | step to the next lower exponent bit, or finish
// FIN      | publish result, done pulse follows on return to IDLE
// ---------------------------------------------------------------------------
module modexp_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] msg,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] mod,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             err,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [WIDTH-1:0] mul_n,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_r
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        SQ_REQ,
        SQ_WAIT,
        MUL_REQ,
        MUL_WAIT,
        NEXT,
        FIN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] msg_l;
    logic [WIDTH-1:0] exp_l;
    logic [WIDTH-1:0] acc;
    logic [IW-1:0]    idx;

    // mul_start and the operand registers are loaded on the edge that enters
    // a *_REQ state, so the pulse coincides with that state and the operands
    // are already valid alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            mul_start <= 1'b0;
            result    <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_n     <= '0;
            msg_l     <= '0;
            exp_l     <= '0;
            acc       <= '0;
            idx       <= '0;
        end else begin
            done      <= 1'b0;
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        msg_l <= msg;
                        exp_l <= exp;
                        mul_n <= mod;
                        idx   <= IW'(WIDTH - 1);
                        ready <= 1'b0;
                        if (mod < WIDTH'(2) || msg >= mod) begin
                            err   <= 1'b1;
                            acc   <= '0;
                            state <= FIN;
                        end else begin
                            err       <= 1'b0;
                            acc       <= WIDTH'(1);
                            mul_a     <= WIDTH'(1);
                            mul_b     <= WIDTH'(1);
                            mul_start <= 1'b1;
                            state     <= SQ_REQ;
                        end
                    end
                end
                SQ_REQ: state <= SQ_WAIT;
                SQ_WAIT: begin
                    if (mul_done) begin
                        acc <= mul_r;
                        if (exp_l[idx]) begin
                            mul_a     <= mul_r;
                            mul_b     <= msg_l;
                            mul_start <= 1'b1;
                            state     <= MUL_REQ;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                MUL_REQ: state <= MUL_WAIT;
                MUL_WAIT: begin
                    if (mul_done) begin
                        acc   <= mul_r;
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx == '0) begin
                        state <= FIN;
                    end else begin
                        idx       <= idx - IW'(1);
                        mul_a     <= acc;
                        mul_b     <= acc;
                        mul_start <= 1'b1;
                        state     <= SQ_REQ;
                    end
                end
                FIN: begin
                    result <= acc;
                    done   <= 1'b1;
                    ready  <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
